fmul_norm_round: RTL

- Back-end stage of the single-precision FP multiplier. It sits directly downstream of the 24x24 mantissa multiplier and consumes its raw 48-bit product, together with the operand signs, biased exponents and upstream special-case flags.
- It normalises the product, applies rounding, detects overflow/underflow, and packs an IEEE-754 binary32 result.
- It is a 2-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/fmul_norm_round.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fmul_norm_round.sv
// Normalise/round/pack back-end of the binary32 multiplier: a 2-stage valid/ready pipeline.
// Define FMUL_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fmul_norm_round #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned BIAS  = 127
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       sign_a,
  input  logic                       sign_b,
  input  logic [EXP_W-1:0]           exp_a,
  input  logic [EXP_W-1:0]           exp_b,
  input  logic [2*(MAN_W+1)-1:0]     prod,
  input  logic                       in_zero,
  input  logic                       in_inf,
  input  logic                       in_nan,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       result,
  output logic                       ovf,
  output logic                       unf,
  output logic                       inexact
);

  localparam int unsigned PW = 2 * (MAN_W + 1);
  localparam int unsigned EW = EXP_W + 2;

  logic s1_adv, s2_adv;
  logic s1_valid, s2_valid;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Stage 1: normalise the raw product
  logic [EW-1:0]    e_n;
  logic [MAN_W-1:0] frac_n;
  logic             guard_n, sticky_n;

  always_comb begin
    e_n = {2'b00, exp_a} + {2'b00, exp_b} - EW'(BIAS) + {{(EW-1){1'b0}}, prod[PW-1]};
    if (prod[PW-1]) begin
      frac_n   = prod[PW-2 -: MAN_W];
      guard_n  = prod[PW-MAN_W-2];
      sticky_n = |prod[PW-MAN_W-3:0];
    end else begin
      frac_n   = prod[PW-3 -: MAN_W];
      guard_n  = prod[PW-MAN_W-3];
      sticky_n = |prod[PW-MAN_W-4:0];
    end
  end

  logic             s1_sign, s1_guard, s1_sticky, s1_zero, s1_inf, s1_nan;
  logic [EW-1:0]    s1_e;
  logic [MAN_W-1:0] s1_frac;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_e      <= '0;
      s1_frac   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_zero   <= 1'b0;
      s1_inf    <= 1'b0;
      s1_nan    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign   <= sign_a ^ sign_b;
        s1_e      <= e_n;
        s1_frac   <= frac_n;
        s1_guard  <= guard_n;
        s1_sticky <= sticky_n;
        s1_zero   <= in_zero;
        s1_inf    <= in_inf;
        s1_nan    <= in_nan;
      end
    end
  end

  // Stage 2: round, range-check and pack
  logic [MAN_W-1:0] frac_r;
  logic [EW-1:0]    e_r;

`ifdef FMUL_RNE_EN
  logic             round_up;
  logic [MAN_W:0]   frac_sum;

  always_comb begin
    round_up = s1_guard && (s1_sticky || s1_frac[0]);
    frac_sum = {1'b0, s1_frac} + {{MAN_W{1'b0}}, round_up};
    // All-ones fraction rounding up wraps to zero and bumps the exponent
    frac_r   = frac_sum[MAN_W-1:0];
    e_r      = s1_e + {{(EW-1){1'b0}}, frac_sum[MAN_W]};
  end
`else
  always_comb begin
    frac_r = s1_frac;
    e_r    = s1_e;
  end
`endif

  logic [EXP_W+MAN_W:0] result_d;
  logic                 ovf_d, unf_d, inexact_d;

  always_comb begin
    result_d  = '0;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    inexact_d = 1'b0;
    if (s1_nan) begin
      result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (s1_inf) begin
      result_d = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s1_zero) begin
      result_d = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if ($signed(e_r) >= $signed({2'b00, {EXP_W{1'b1}}})) begin
      result_d  = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d     = 1'b1;
      inexact_d = 1'b1;
    end else if ($signed(e_r) <= $signed({EW{1'b0}})) begin
      result_d  = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
      unf_d     = 1'b1;
      inexact_d = 1'b1;
    end else begin
      result_d  = {s1_sign, e_r[EXP_W-1:0], frac_r};
      inexact_d = s1_guard || s1_sticky;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      inexact  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result  <= result_d;
        ovf     <= ovf_d;
        unf     <= unf_d;
        inexact <= inexact_d;
      end
    end
  end

endmodule
